// File: rtl/dual_dm_io_responder.sv
// rtl/dual_dm_io_responder.sv - dual-core DM responder: RAM/I-O decode, write conflict arbitration, board I/O, inter-core lock
module dual_dm_io_responder #(
    parameter int SW_W  = 10,
    parameter int HEX_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       p0_DM_maddr,
    input  logic [15:0]      p0_DM_wdata,
    input  logic             p0_DM_write_mem,
    output logic [15:0]      p0_DM_rdata,
    input  logic [8:0]       p1_DM_maddr,
    input  logic [15:0]      p1_DM_wdata,
    input  logic             p1_DM_write_mem,
    output logic [15:0]      p1_DM_rdata,
    output logic [7:0]       ram_addr_a,
    output logic [7:0]       ram_addr_b,
    output logic [15:0]      ram_data_a,
    output logic [15:0]      ram_data_b,
    output logic             ram_we_a,
    output logic             ram_we_b,
    input  logic [15:0]      ram_q_a,
    input  logic [15:0]      ram_q_b,
    input  logic [SW_W-1:0]  SW,
    output logic [SW_W-1:0]  LEDR,
    output logic [HEX_W-1:0] hex_value,
    output logic [CNT_W-1:0] conflict_count
);

    localparam logic [8:0] ADDR_SW   = 9'h100;
    localparam logic [8:0] ADDR_LEDR = 9'h101;
    localparam logic [8:0] ADDR_HEX  = 9'h102;
    localparam logic [8:0] ADDR_LOCK = 9'h103;
    localparam logic [8:0] ADDR_CNT  = 9'h104;

    typedef enum logic [1:0] {
        LOCK_FREE = 2'd0,
        LOCK_OWN0 = 2'd1,
        LOCK_OWN1 = 2'd2
    } lock_state_t;

    lock_state_t      lock_state;
    logic [SW_W-1:0]  sw_meta;
    logic [SW_W-1:0]  sw_sync;
    logic [SW_W-1:0]  ledr_q;
    logic [HEX_W-1:0] hex_q;
    logic [CNT_W-1:0] cnt_q;

    logic             conflict;
    logic             wr0_eff;
    logic             wr1_eff;
    logic             lock_rd0;
    logic             lock_rd1;
    logic             lock_val0;
    logic             lock_val1;
    logic             cnt_clear;
    logic [15:0]      sw_ext;
    logic [15:0]      ledr_ext;
    logic [15:0]      hex_ext;
    logic [15:0]      cnt_ext;
    logic [15:0]      io_rd0;
    logic [15:0]      io_rd1;
    logic             sel_io0;
    logic             sel_io1;
    logic [15:0]      io_q0;
    logic [15:0]      io_q1;

    function automatic logic [15:0] io_read(
        input logic [8:0]  addr,
        input logic        lock_bit,
        input logic [15:0] sw_v,
        input logic [15:0] ledr_v,
        input logic [15:0] hex_v,
        input logic [15:0] cnt_v
    );
        logic [15:0] v;
        case (addr)
            ADDR_SW:   v = sw_v;
            ADDR_LEDR: v = ledr_v;
            ADDR_HEX:  v = hex_v;
            ADDR_LOCK: v = {15'd0, lock_bit};
            ADDR_CNT:  v = cnt_v;
            default:   v = 16'd0;
        endcase
        return v;
    endfunction

    always_comb begin
        conflict  = p0_DM_write_mem & p1_DM_write_mem & (p0_DM_maddr == p1_DM_maddr);
        // core 1 always wins a same-address write, so only core 0 is ever suppressed
        wr0_eff   = p0_DM_write_mem & ~conflict;
        wr1_eff   = p1_DM_write_mem;
        lock_rd0  = (p0_DM_maddr == ADDR_LOCK) & ~p0_DM_write_mem;
        lock_rd1  = (p1_DM_maddr == ADDR_LOCK) & ~p1_DM_write_mem;
        // port 0 has priority when both ports try to take a free lock
        lock_val0 = (lock_state == LOCK_OWN1);
        lock_val1 = (lock_state == LOCK_OWN0) | ((lock_state == LOCK_FREE) & lock_rd0);
        cnt_clear = (wr0_eff & (p0_DM_maddr == ADDR_CNT)) | (wr1_eff & (p1_DM_maddr == ADDR_CNT));
        sw_ext    = 16'(sw_sync);
        ledr_ext  = 16'(ledr_q);
        hex_ext   = 16'(hex_q);
        cnt_ext   = 16'(cnt_q);
        io_rd0    = io_read(p0_DM_maddr, lock_val0, sw_ext, ledr_ext, hex_ext, cnt_ext);
        io_rd1    = io_read(p1_DM_maddr, lock_val1, sw_ext, ledr_ext, hex_ext, cnt_ext);
    end

    assign ram_addr_a     = p0_DM_maddr[7:0];
    assign ram_addr_b     = p1_DM_maddr[7:0];
    assign ram_data_a     = p0_DM_wdata;
    assign ram_data_b     = p1_DM_wdata;
    assign ram_we_a       = p0_DM_write_mem & ~p0_DM_maddr[8] & ~conflict;
    assign ram_we_b       = p1_DM_write_mem & ~p1_DM_maddr[8];

    assign p0_DM_rdata    = sel_io0 ? io_q0 : ram_q_a;
    assign p1_DM_rdata    = sel_io1 ? io_q1 : ram_q_b;
    assign LEDR           = ledr_q;
    assign hex_value      = hex_q;
    assign conflict_count = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta    <= '0;
            sw_sync    <= '0;
            ledr_q     <= '0;
            hex_q      <= '0;
            cnt_q      <= '0;
            lock_state <= LOCK_FREE;
            sel_io0    <= 1'b1;
            sel_io1    <= 1'b1;
            io_q0      <= 16'd0;
            io_q1      <= 16'd0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
            sel_io0 <= p0_DM_maddr[8];
            sel_io1 <= p1_DM_maddr[8];
            io_q0   <= io_rd0;
            io_q1   <= io_rd1;

            if (wr1_eff && p1_DM_maddr == ADDR_LEDR)
                ledr_q <= p1_DM_wdata[SW_W-1:0];
            else if (wr0_eff && p0_DM_maddr == ADDR_LEDR)
                ledr_q <= p0_DM_wdata[SW_W-1:0];

            if (wr1_eff && p1_DM_maddr == ADDR_HEX)
                hex_q <= p1_DM_wdata[HEX_W-1:0];
            else if (wr0_eff && p0_DM_maddr == ADDR_HEX)
                hex_q <= p0_DM_wdata[HEX_W-1:0];

            // a clear beats the increment even when the clearing write is itself a conflict
            if (cnt_clear)
                cnt_q <= '0;
            else if (conflict && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + 1'b1;

            case (lock_state)
                LOCK_FREE: begin
                    if (lock_rd0)
                        lock_state <= LOCK_OWN0;
                    else if (lock_rd1)
                        lock_state <= LOCK_OWN1;
                end
                LOCK_OWN0: begin
                    if (wr0_eff && p0_DM_maddr == ADDR_LOCK)
                        lock_state <= LOCK_FREE;
                end
                LOCK_OWN1: begin
                    if (wr1_eff && p1_DM_maddr == ADDR_LOCK)
                        lock_state <= LOCK_FREE;
                end
                default: lock_state <= LOCK_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_dual_dm_io_responder.sv
// tb/tb_dual_dm_io_responder.sv - directed plus randomized check of dual_dm_io_responder against a behavioural model
module tb_dual_dm_io_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  a0, a1;
    logic [15:0] d0, d1;
    logic        w0, w1;
    logic [9:0]  sw;
    logic [15:0] rd0, rd1;
    logic [7:0]  ram_addr_a, ram_addr_b;
    logic [15:0] ram_data_a, ram_data_b;
    logic        ram_we_a, ram_we_b;
    logic [15:0] ram_q_a, ram_q_b;
    logic [9:0]  ledr;
    logic [15:0] hex_value;
    logic [15:0] conflict_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dual_dm_io_responder #(.SW_W(10), .HEX_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .p0_DM_maddr(a0), .p0_DM_wdata(d0), .p0_DM_write_mem(w0), .p0_DM_rdata(rd0),
        .p1_DM_maddr(a1), .p1_DM_wdata(d1), .p1_DM_write_mem(w1), .p1_DM_rdata(rd1),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
        .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
        .ram_q_a(ram_q_a), .ram_q_b(ram_q_b),
        .SW(sw), .LEDR(ledr), .hex_value(hex_value), .conflict_count(conflict_count)
    );

    // physical true dual-port RAM, read-before-write on each port
    logic [15:0] ram_mem [256] = '{default: 16'h0};
    always @(posedge clk) begin
        ram_q_a <= ram_mem[ram_addr_a];
        ram_q_b <= ram_mem[ram_addr_b];
        if (ram_we_a) ram_mem[ram_addr_a] <= ram_data_a;
        if (ram_we_b) ram_mem[ram_addr_b] <= ram_data_b;
    end

    // reference model state
    logic [15:0] ref_mem [256] = '{default: 16'h0};
    logic [9:0]  m_ledr, m_s1, m_s2;
    logic [15:0] m_hex, m_cnt;
    int          m_owner;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_io(input logic [8:0] addr, input int port);
        case (addr)
            9'h100: return {6'd0, m_s2};
            9'h101: return {6'd0, m_ledr};
            9'h102: return m_hex;
            9'h103: begin
                if (port == 0) return {15'd0, m_owner == 1};
                return {15'd0, (m_owner == 0) || (m_owner < 0 && a0 == 9'h103 && !w0)};
            end
            9'h104: return m_cnt;
            default: return 16'd0;
        endcase
    endfunction

    task automatic set_in(input logic [8:0] aa0, input logic [15:0] dd0, input logic ww0,
                          input logic [8:0] aa1, input logic [15:0] dd1, input logic ww1);
        a0 = aa0; d0 = dd0; w0 = ww0;
        a1 = aa1; d1 = dd1; w1 = ww1;
    endtask

    // one clock: called just after a falling edge with inputs already driven
    task automatic do_cycle(input bit chk);
        logic        cf, e0w, e1w;
        logic [15:0] e0, e1;
        bit          v0, v1;
        #1;
        cf  = w0 && w1 && (a0 == a1);
        e0w = w0 && !cf;
        e1w = w1;
        if (chk) begin
            check_eq("ram_we_a", ram_we_a, w0 && !a0[8] && !cf);
            check_eq("ram_we_b", ram_we_b, w1 && !a1[8]);
            check_eq("ram_addr_a", ram_addr_a, a0[7:0]);
            check_eq("ram_data_b", ram_data_b, d1);
        end
        e0 = a0[8] ? m_io(a0, 0) : ref_mem[a0[7:0]];
        e1 = a1[8] ? m_io(a1, 1) : ref_mem[a1[7:0]];
        v0 = !w0;
        v1 = !w1;
        if (e1w && !a1[8]) ref_mem[a1[7:0]] = d1;
        if (e0w && !a0[8]) ref_mem[a0[7:0]] = d0;
        if (rst) begin
            e0 = 16'd0; e1 = 16'd0; v0 = 1; v1 = 1;
            m_ledr = 0; m_hex = 0; m_cnt = 0; m_owner = -1; m_s1 = 0; m_s2 = 0;
        end else begin
            m_s2 = m_s1;
            m_s1 = sw;
            if (e1w && a1 == 9'h101) m_ledr = d1[9:0];
            else if (e0w && a0 == 9'h101) m_ledr = d0[9:0];
            if (e1w && a1 == 9'h102) m_hex = d1;
            else if (e0w && a0 == 9'h102) m_hex = d0;
            if ((e0w && a0 == 9'h104) || (e1w && a1 == 9'h104)) m_cnt = 0;
            else if (cf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_owner < 0) begin
                if (a0 == 9'h103 && !w0) m_owner = 0;
                else if (a1 == 9'h103 && !w1) m_owner = 1;
            end else if (m_owner == 0 && e0w && a0 == 9'h103) m_owner = -1;
            else if (m_owner == 1 && e1w && a1 == 9'h103) m_owner = -1;
        end
        @(posedge clk);
        #1;
        if (chk) begin
            if (v0) check_eq("p0_rdata", rd0, e0);
            if (v1) check_eq("p1_rdata", rd1, e1);
            check_eq("ledr", ledr, m_ledr);
            check_eq("hex", hex_value, m_hex);
            check_eq("cnt", conflict_count, m_cnt);
        end
        @(negedge clk);
    endtask

    function automatic logic [8:0] pick_addr();
        int r;
        r = $urandom_range(0, 13);
        if (r < 4) return 9'(r);
        if (r == 4) return 9'h020;
        if (r < 10) return 9'h100 + 9'(r - 5);
        if (r < 12) return 9'h103;
        if (r == 12) return 9'h1FF;
        return 9'h105;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sw = 10'h000;
        rst = 1'b1;
        set_in(9'h000, 16'h0, 1'b0, 9'h000, 16'h0, 1'b0);
        do_cycle(1);
        rst = 1'b0;
        check_eq("rst_rd0", rd0, 16'h0);
        check_eq("rst_rd1", rd1, 16'h0);

        set_in(9'h101, 16'h0155, 1'b1, 9'h000, 16'h0, 1'b0);
        do_cycle(1);
        check_eq("ledr_write", ledr, 10'h155);
        set_in(9'h000, 16'h0, 1'b0, 9'h101, 16'h0, 1'b0);
        do_cycle(1);
        check_eq("ledr_read_p1", rd1, 16'h0155);

        set_in(9'h020, 16'hAAAA, 1'b1, 9'h020, 16'h5555, 1'b1);
        #1;
        check_eq("conf_we_a", ram_we_a, 1'b0);
        check_eq("conf_we_b", ram_we_b, 1'b1);
        do_cycle(1);
        set_in(9'h020, 16'h0, 1'b0, 9'h104, 16'h0, 1'b0);
        do_cycle(1);
        check_eq("conf_ram", rd0, 16'h5555);
        check_eq("conf_cnt", rd1, 16'h0001);

        set_in(9'h103, 16'h0, 1'b0, 9'h103, 16'h0, 1'b0);
        do_cycle(1);
        check_eq("lock_both_p0", rd0, 16'h0);
        check_eq("lock_both_p1", rd1, 16'h1);
        set_in(9'h000, 16'h0, 1'b0, 9'h103, 16'h77, 1'b1);
        do_cycle(1);
        set_in(9'h000, 16'h0, 1'b0, 9'h103, 16'h0, 1'b0);
        do_cycle(1);
        check_eq("lock_nonowner_wr", rd1, 16'h1);
        set_in(9'h103, 16'h0, 1'b1, 9'h000, 16'h0, 1'b0);
        do_cycle(1);
        set_in(9'h000, 16'h0, 1'b0, 9'h103, 16'h0, 1'b0);
        do_cycle(1);
        check_eq("lock_handover", rd1, 16'h0);

        set_in(9'h030, 16'h1111, 1'b1, 9'h030, 16'h2222, 1'b1);
        repeat (65540) do_cycle(0);
        check_eq("cnt_saturate", conflict_count, 16'hFFFF);
        set_in(9'h104, 16'h0, 1'b1, 9'h104, 16'h0, 1'b1);
        do_cycle(1);
        check_eq("cnt_conf_clear", conflict_count, 16'h0);

        sw = 10'h3C0;
        set_in(9'h100, 16'h0, 1'b0, 9'h000, 16'h0, 1'b0);
        do_cycle(1);
        do_cycle(1);
        check_eq("sw_early", rd0, 16'h0000);
        do_cycle(1);
        check_eq("sw_sync", rd0, 16'h03C0);

        set_in(9'h1FF, 16'h1234, 1'b1, 9'h000, 16'h0, 1'b0);
        do_cycle(1);
        set_in(9'h1FF, 16'h0, 1'b0, 9'h101, 16'h0, 1'b0);
        do_cycle(1);
        check_eq("unmapped_rd", rd0, 16'h0);
        check_eq("unmapped_wr", rd1, 16'h0155);

        set_in(9'h101, 16'h00FF, 1'b1, 9'h103, 16'h0, 1'b0);
        do_cycle(1);
        check_eq("ledr_ff", ledr, 10'h0FF);
        rst = 1'b1;
        set_in(9'h000, 16'h0, 1'b0, 9'h000, 16'h0, 1'b0);
        do_cycle(1);
        rst = 1'b0;
        check_eq("rst_ledr", ledr, 10'h0);
        check_eq("rst2_rd0", rd0, 16'h0);
        check_eq("rst2_rd1", rd1, 16'h0);
        set_in(9'h103, 16'h0, 1'b0, 9'h000, 16'h0, 1'b0);
        do_cycle(1);
        check_eq("rst_lock_free", rd0, 16'h0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) sw = 10'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            set_in(pick_addr(), 16'($urandom), $urandom_range(0, 9) < 3,
                   pick_addr(), 16'($urandom), $urandom_range(0, 9) < 3);
            if ($urandom_range(0, 9) == 0) a1 = a0;
            do_cycle(1);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dual_dm_io_responder.md
Name: dual_dm_io_responder

Overview:
- Memory-side responder for the two cores' data-memory (DM) ports.
- Decodes each 9-bit DM address into either the 256-word true dual-port RAM (maddr[8]=0) or a memory-mapped I/O page (maddr[8]=1).
- Resolves same-address write conflicts and returns read data with a uniform 1-cycle latency.
- Owns the board I/O registers (switches, LEDs, hex value), a hardware inter-core lock and a conflict counter.
- Sits between the cpu and the RAM in the board top level.

Parameters:
- SW_W, 10, width of switch input and LED register.
- HEX_W, 16, width of the hex display value register.
- CNT_W, 16, width of the saturating conflict counter (CNT_W ≤ 16).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- p0_DM_maddr  in  9  core 0 data address.
- p0_DM_wdata  in  16  core 0 write data.
- p0_DM_write_mem  in  1  core 0 write strobe.
- p0_DM_rdata  out  16  core 0 read data, 1 cycle after address.
- p1_DM_maddr / p1_DM_wdata / p1_DM_write_mem / p1_DM_rdata  same widths and meanings for core 1.
- ram_addr_a, ram_addr_b  out  8  RAM port A/B address = pN_DM_maddr[7:0], combinational.
- ram_data_a, ram_data_b  out  16  RAM write data = pN_DM_wdata, combinational.
- ram_we_a, ram_we_b  out  1  RAM write enables, combinational.
- ram_q_a, ram_q_b  in  16  RAM synchronous read data (valid 1 cycle after address).
- SW  in  SW_W  asynchronous board switches.
- LEDR  out  SW_W  LED register.
- hex_value  out  HEX_W  hex display register (segment decode is external).
- conflict_count  out  CNT_W  mirror of the counter, for debug.

Behaviour:
- I/O map (maddr[8]=1):
  - 0x100 SW: read-only; value after 2-flop synchroniser, zero-extended.
  - 0x101 LEDR: R/W; bits [SW_W-1:0].
  - 0x102 HEX: R/W.
  - 0x103 LOCK: special, see below.
  - 0x104 CNT: read returns the counter; any write clears it.
  - All other I/O addresses: read 0, writes ignored.
- RAM enables: ram_we_b = p1_write & ~maddr1[8]; ram_we_a = p0_write & ~maddr0[8] & ~conflict.
- Conflict: p0_write & p1_write & (maddr0 == maddr1), full 9-bit compare, applies to RAM and I/O alike.
- On conflict:
  - Core 1 wins and core 0's write is dropped.
  - Counter increments by 1 and saturates at all-ones.
  - If the conflict is itself a write to 0x104, the clear wins and the counter becomes 0.
- Read path:
  - Per port, register sel_io <= maddr[8] and io_q <= I/O read value (for the current maddr), every cycle.
  - pN_DM_rdata = sel_io ? io_q : ram_q_N.
  - Latency is exactly 1 cycle for both regions.
  - An I/O read in the same cycle as a write to that register returns the old value.
- LOCK state machine, states FREE / OWN0 / OWN1:
  - A read access means maddr = 0x103 with write_mem = 0, evaluated every cycle; repeated reads are idempotent.
  - Read by port n: FREE → OWNn, returns 0; OWNn → stays, returns 0; owned by the other port → returns 1.
  - Both ports read while FREE in the same cycle: p0 gets 0 → OWN0; p1 gets 1.
  - Write to 0x103 by the owner → FREE (data ignored). A write by a non-owner, or while FREE, is ignored.
  - Owner release and other-port read in the same cycle: the reader sees 1 (evaluated against the current state); state becomes FREE.
- Reset (rst=1 at a clock edge; takes priority over all writes that cycle):
  - LEDR = 0, hex_value = 0, counter = 0, LOCK = FREE.
  - sel_io = 1 and io_q = 0, so both rdata = 0 in the cycle after reset.
  - SW synchroniser flops = 0.
  - RAM enables remain combinational. The RAM is not cleared; RAM contents are not reset.
- Reset asserted mid-operation releases the lock regardless of owner.

Test Plan:
- Reset, then p0 writes 0x0155 to 0x101 → LEDR=0x155 next cycle. p1 reads 0x101 → p1_DM_rdata=0x0155 one cycle after the address.
- p0 and p1 both write address 0x020 (0xAAAA / 0x5555) in one cycle → ram_we_a=0, ram_we_b=1. Next-cycle read of 0x020 returns 0x5555; read of 0x104 returns 1.
- Both cores read 0x103 from FREE in the same cycle → p0 gets 0, p1 gets 1. p1 writes 0x103 → ignored, p1 still reads 1. p0 writes 0x103 → p1's next read gets 0 and p1 becomes owner.
- Force 0xFFFF conflicts (or preload the counter) → counter holds 0xFFFF. A conflicting write to 0x104 → counter 0.
- SW=0x3C0 → core read of 0x100 returns 0x03C0 no earlier than the 2-flop sync plus 1 cycle. Reads of 0x1FF return 0, and a write to 0x1FF changes nothing.
- p1 holds the lock and LEDR=0x0FF; assert rst for 1 cycle → LEDR=0, lock FREE (p0 read of 0x103 returns 0), both rdata=0 the cycle after reset.
